bp_fe_compressor: RTL and testbench
===================================

BP_FE_COMPRESSOR -- requirements
Module: bp_fe_compressor

Interface
REQ-001 SHALL have parameter cfg_p, default e_bp_inv_cfg, selecting the processor configuration; instr_width_p (32) and dword_width_p derive from it.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port instr_i, input, instr_width_p, the uncompressed RV64 instruction.
REQ-005 SHALL have port v_i, input, 1, instr_i valid.
REQ-006 SHALL have port ready_o, output, 1, block accepts instr_i this cycle.
REQ-007 SHALL have port flush_i, input, 1, pad and emit any pending halfword.
REQ-008 SHALL have port data_o, output, instr_width_p, the packed fetch word, lower halfword first (little-endian).
REQ-009 SHALL have port v_o, output, 1, data_o valid.
REQ-010 SHALL have port yumi_i, input, 1, consumer takes data_o this cycle; legal only while v_o=1.

Function
REQ-011 Input handshake: an instruction is accepted when v_i & ready_o.
REQ-012 ready_o SHALL equal (~v_o | yumi_i) & ~flush_i.
REQ-013 Output handshake: data_o/v_o are registered; data_o SHALL hold stable while v_o=1 & ~yumi_i.
REQ-014 Compression SHALL be combinational on instr_i and map to the standard RVC encoding:
- addi x0,x0,0 -> C.NOP.
- ebreak -> C.EBREAK.
- addi rd,x0,imm (rd!=0, imm in [-32,31]) -> C.LI.
- addi rd,rd,imm (rd!=0, imm!=0, imm in [-32,31]) -> C.ADDI.
- add rd,x0,rs2 (rd,rs2!=0) -> C.MV.
- add rd,rd,rs2 (rd,rs2!=0) -> C.ADD.
- sub/xor/or/and rd,rd,rs2 (rd,rs2 in x8-x15) -> C.SUB/C.XOR/C.OR/C.AND.
- jal x0,off (off even, in [-2048,2046]) -> C.J.
- jalr x0,0(rs1) (rs1!=0) -> C.JR.
- jalr x1,0(rs1) (rs1!=0) -> C.JALR.
- lw/ld rd',off(rs1') (regs x8-x15; off 4-/8-byte aligned, in [0,124]/[0,248]) -> C.LW/C.LD.
- sw/sd with the same constraints -> C.SW/C.SD.
- Everything else: not compressible, emitted as 32 bits unchanged, including inputs with instr_i[1:0]!=2'b11.
REQ-015 When several rows match, SHALL apply the list order above; the first match wins.
REQ-016 State machine e_empty (no pending halfword) / e_half (pending halfword in a 16-bit register pend_r). Transitions on accept:
- e_empty + compressed c: pend_r<=c, go to e_half, no output.
- e_empty + 32-bit w: data_o<=w, v_o<=1, stay in e_empty.
- e_half + compressed c: data_o<={c,pend_r}, v_o<=1, go to e_empty.
- e_half + 32-bit w: data_o<={w[15:0],pend_r}, v_o<=1, pend_r<=w[31:16], stay in e_half (straddle).
REQ-017 Flush:
- In e_half with the output slot free (~v_o | yumi_i): data_o<={16'h0001,pend_r}, v_o<=1, go to e_empty.
- In e_empty: no-op.
- flush_i SHALL be held until the slot is free; it SHALL NOT be lost.
REQ-018 Latency: one cycle from accept to v_o for any emitting transition; throughput one instruction per cycle when yumi_i is held high.
REQ-019 v_o SHALL clear on yumi_i unless a new word is loaded in the same cycle.
REQ-020 Instruction order SHALL be preserved; no halfword SHALL be dropped or duplicated.

Reset
REQ-021 reset_i=1 SHALL force state=e_empty, v_o=0, data_o=0, pend_r=0; ready_o=1 the cycle after reset deasserts.
REQ-022 reset_i SHALL take priority over v_i, flush_i and yumi_i, and SHALL discard pending and unconsumed data mid-operation.

Verification
REQ-023 Scenario 1: e_empty, instr_i=0x00140413 (addi x8,x8,1), then 0x00B00533 (add x10,x0,x11), yumi_i=1 -> no output after first; then data_o=0x852E0405, v_o=1.
REQ-024 Scenario 2: e_empty, instr_i=0x123452B7 (lui) -> next cycle data_o=0x123452B7, state e_empty.
REQ-025 Scenario 3: pending 0x0405, instr_i=0x123452B7 -> data_o=0x52B70405, pend_r=0x1234; then flush_i=1 -> data_o=0x00011234, state e_empty.
REQ-026 Scenario 4: v_o=1 with yumi_i=0 for 3 cycles, v_i=1 -> ready_o=0 and data_o unchanged for those cycles; yumi_i=1 -> ready_o=1, and the held input is emitted next cycle.
REQ-027 Scenario 5: e_empty, instr_i=0x00100073 (ebreak), then 0x00000013 (nop) -> data_o=0x00019002.
REQ-028 Scenario 6: reset_i=1 while in e_half with v_o=1 -> next cycle v_o=0, data_o=0, state e_empty; a following compressed instruction is not merged with the old pending halfword.

Source files
------------

// File: rtl/bp_fe_compressor.sv
// RVC compressor and halfword packer for the BlackParrot front end: compresses each
// accepted RV64 instruction where possible and packs halfwords into 32-bit fetch words.
`timescale 1ns/1ps

package bp_fe_compressor_pkg;
    typedef enum logic [1:0] {
        e_bp_inv_cfg,
        e_bp_default_cfg,
        e_bp_unicore_cfg
    } bp_params_e;

    // Every supported configuration is RV64.
    function automatic int dword_width(bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: dword_width = 64;
            default:      dword_width = 64;
        endcase
    endfunction
endpackage

module bp_fe_compressor
    import bp_fe_compressor_pkg::*;
#(
    parameter bp_params_e cfg_p = e_bp_inv_cfg,
    localparam int instr_width_p = 32,
    localparam int dword_width_p = dword_width(cfg_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [instr_width_p-1:0] instr_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    output logic [instr_width_p-1:0] data_o,
    output logic                     v_o,
    input  logic                     yumi_i
);
    localparam logic rv64_en = (dword_width_p == 64);

    typedef enum logic {e_empty, e_half} state_e;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm_i, imm_s;
    logic [20:1] imm_j;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];
    assign imm_i  = instr_i[31:20];
    assign imm_s  = {instr_i[31:25], instr_i[11:7]};
    assign imm_j  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]};

    logic is_addi, is_add, fits6, j_fits, rd_p, rs1_p, rs2_p, alu_ok, is_jalr0;
    logic [1:0] alu_f2;

    assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign fits6    = (&imm_i[11:5]) || !(|imm_i[11:5]);
    assign j_fits   = (&imm_j[20:11]) || !(|imm_j[20:11]);
    assign rd_p     = (rd[4:3] == 2'b01);
    assign rs1_p    = (rs1[4:3] == 2'b01);
    assign rs2_p    = (rs2[4:3] == 2'b01);
    assign is_jalr0 = (opcode == 7'b1100111) && (funct3 == 3'b000) && (imm_i == 12'd0);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        alu_ok = 1'b0;
        alu_f2 = 2'b00;
        if (opcode == 7'b0110011) begin
            if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                alu_ok = 1'b1;
                alu_f2 = 2'b00;
            end else if (funct7 == 7'b0000000 && funct3 == 3'b100) begin
                alu_ok = 1'b1;
                alu_f2 = 2'b01;
            end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
                alu_ok = 1'b1;
                alu_f2 = 2'b10;
            end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
                alu_ok = 1'b1;
                alu_f2 = 2'b11;
            end
        end
    end

    logic        comp;
    logic [15:0] c_instr;

    // Row order is the match priority: the first matching row wins.
    always_comb begin
        comp    = 1'b1;
        c_instr = 16'h0000;
        if (instr_i == 32'h0000_0013)
            c_instr = 16'h0001;
        else if (instr_i == 32'h0010_0073)
            c_instr = 16'h9002;
        else if (is_addi && rs1 == 5'd0 && rd != 5'd0 && fits6)
            c_instr = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        else if (is_addi && rs1 == rd && rd != 5'd0 && imm_i != 12'd0 && fits6)
            c_instr = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
            c_instr = {4'b1000, rd, rs2, 2'b10};
        else if (is_add && rs1 == rd && rd != 5'd0 && rs2 != 5'd0)
            c_instr = {4'b1001, rd, rs2, 2'b10};
        else if (alu_ok && rs1 == rd && rd_p && rs2_p)
            c_instr = {6'b100011, rd[2:0], alu_f2, rs2[2:0], 2'b01};
        else if (opcode == 7'b1101111 && rd == 5'd0 && j_fits)
            c_instr = {3'b101, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10], imm_j[6],
                       imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
        else if (is_jalr0 && rd == 5'd0 && rs1 != 5'd0)
            c_instr = {4'b1000, rs1, 5'd0, 2'b10};
        else if (is_jalr0 && rd == 5'd1 && rs1 != 5'd0)
            c_instr = {4'b1001, rs1, 5'd0, 2'b10};
        else if (opcode == 7'b0000011 && funct3 == 3'b010 && rd_p && rs1_p
                 && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0)
            c_instr = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        else if (rv64_en && opcode == 7'b0000011 && funct3 == 3'b011 && rd_p && rs1_p
                 && imm_i[11:8] == 4'd0 && imm_i[2:0] == 3'd0)
            c_instr = {3'b011, imm_i[5:3], rs1[2:0], imm_i[7:6], rd[2:0], 2'b00};
        else if (opcode == 7'b0100011 && funct3 == 3'b010 && rs2_p && rs1_p
                 && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0)
            c_instr = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        else if (rv64_en && opcode == 7'b0100011 && funct3 == 3'b011 && rs2_p && rs1_p
                 && imm_s[11:8] == 4'd0 && imm_s[2:0] == 3'd0)
            c_instr = {3'b111, imm_s[5:3], rs1[2:0], imm_s[7:6], rs2[2:0], 2'b00};
        else
            comp = 1'b0;
    end

    state_e      state_r, state_n;
    logic [15:0] pend_r, pend_n;
    logic [31:0] data_r, data_n;
    logic        v_r, v_n;
    logic        slot_free, accept, flush_fire;

    assign slot_free  = !v_r || yumi_i;
    assign ready_o    = slot_free && !flush_i;
    assign accept     = v_i && ready_o;
    assign flush_fire = flush_i && slot_free && (state_r == e_half);
    assign data_o     = data_r;
    assign v_o        = v_r;

    always_comb begin
        state_n = state_r;
        pend_n  = pend_r;
        data_n  = data_r;
        v_n     = v_r && !yumi_i;
        if (accept) begin
            unique case (state_r)
                e_empty: begin
                    if (comp) begin
                        pend_n  = c_instr;
                        state_n = e_half;
                    end else begin
                        data_n = instr_i;
                        v_n    = 1'b1;
                    end
                end
                e_half: begin
                    v_n = 1'b1;
                    if (comp) begin
                        data_n  = {c_instr, pend_r};
                        state_n = e_empty;
                    end else begin
                        // Straddle: low half completes this word, high half stays pending.
                        data_n = {instr_i[15:0], pend_r};
                        pend_n = instr_i[31:16];
                    end
                end
                default: state_n = e_empty;
            endcase
        end else if (flush_fire) begin
            data_n  = {16'h0001, pend_r};
            v_n     = 1'b1;
            state_n = e_empty;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: the datapath registers are reset too, because a cleared data_o is observable.
            state_r <= e_empty;
            pend_r  <= 16'h0000;
            data_r  <= 32'h0000_0000;
            v_r     <= 1'b0;
        end else begin
            state_r <= state_n;
            pend_r  <= pend_n;
            data_r  <= data_n;
            v_r     <= v_n;
        end
    end
endmodule

// File: tb/tb_bp_fe_compressor.sv
// Directed bench for bp_fe_compressor: a halfword-queue model predicts every output word,
// and literal checks pin the scenario results.
`timescale 1ns/1ps

module tb_bp_fe_compressor;
    typedef struct {
        logic [31:0] instr;
        logic        c;
        logic [15:0] hw;
    } vec_t;

    function automatic vec_t vc(input logic [31:0] w, input logic [15:0] h);
        vec_t r;
        r.instr = w; r.c = 1'b1; r.hw = h;
        return r;
    endfunction

    function automatic vec_t v32(input logic [31:0] w);
        vec_t r;
        r.instr = w; r.c = 1'b0; r.hw = 16'h0000;
        return r;
    endfunction

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] instr_i = 32'h0;
    logic        v_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        yumi_en = 1'b1;
    logic        ready_o, v_o, yumi_i;
    logic [31:0] data_o;

    assign yumi_i = yumi_en & v_o;

    bp_fe_compressor dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .instr_i(instr_i),
        .v_i    (v_i),
        .ready_o(ready_o),
        .flush_i(flush_i),
        .data_o (data_o),
        .v_o    (v_o),
        .yumi_i (yumi_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the accepted instruction stream as a queue of halfwords; any two
    // queued halfwords form the next fetch word, a flush pads a lone one with C.NOP.
    vec_t        cur;
    logic [15:0] hq[$];
    logic        exp_v = 1'b0;
    logic [31:0] exp_data = 32'h0;
    logic        armed = 1'b0;

    always @(posedge clk) begin
        logic        slot, nv;
        logic [31:0] nd;
        logic [15:0] lo, hi;
        if (reset_i) begin
            hq.delete();
            exp_v    <= 1'b0;
            exp_data <= 32'h0;
            armed    <= 1'b1;
        end else if (armed) begin
            slot = !exp_v || yumi_i;
            nv   = exp_v && !yumi_i;
            nd   = exp_data;
            if (v_i && slot && !flush_i) begin
                if (cur.c) hq.push_back(cur.hw);
                else begin
                    hq.push_back(cur.instr[15:0]);
                    hq.push_back(cur.instr[31:16]);
                end
                if (hq.size() >= 2) begin
                    lo = hq.pop_front();
                    hi = hq.pop_front();
                    nd = {hi, lo};
                    nv = 1'b1;
                end
            end else if (flush_i && slot && hq.size() == 1) begin
                lo = hq.pop_front();
                nd = {16'h0001, lo};
                nv = 1'b1;
            end
            exp_v    <= nv;
            exp_data <= nd;
        end
    end

    always @(negedge clk) begin
        if (armed && !reset_i) begin
            check("v_o", {31'd0, v_o}, {31'd0, exp_v});
            check("data_o", data_o, exp_data);
            check("ready_o", {31'd0, ready_o}, {31'd0, (!exp_v || yumi_i) && !flush_i});
        end
    end

    task automatic step(input logic v, input vec_t vv, input logic fl);
        cur     = vv;
        instr_i = vv.instr;
        v_i     = v;
        flush_i = fl;
        @(posedge clk);
        #1;
    endtask

    vec_t addi8, mv, lui, ebrk, nop, and7, idle;
    vec_t tbl[21];

    initial begin
        addi8 = vc(32'h00140413, 16'h0405);
        mv    = vc(32'h00B00533, 16'h852E);
        lui   = v32(32'h123452B7);
        ebrk  = vc(32'h00100073, 16'h9002);
        nop   = vc(32'h00000013, 16'h0001);
        and7  = v32(32'h0083F3B3);
        idle  = v32(32'h00000000);
        tbl = '{
            vc(32'hFFF00293, 16'h52FD), vc(32'hFE000293, 16'h5281), v32(32'h02000293),
            v32(32'h00040413),          vc(32'h00B50533, 16'h952E), vc(32'h40940433, 16'h8C05),
            vc(32'h00F4F4B3, 16'h8CFD), v32(32'h0083F3B3),          vc(32'h0080006F, 16'hA021),
            vc(32'h801FF06F, 16'hB001), v32(32'h0010006F),          v32(32'h008000EF),
            vc(32'h00008067, 16'h8082), vc(32'h000280E7, 16'h9282), vc(32'h07C52483, 16'h5D64),
            v32(32'h08052483),          v32(32'h00252483),          vc(32'h0F87B403, 16'h7FE0),
            vc(32'h00942223, 16'hC044), vc(32'h00A5B823, 16'hE988), v32(32'h12340002)
        };

        // Reset state
        reset_i = 1'b1;
        step(1'b0, idle, 1'b0);
        step(1'b0, idle, 1'b0);
        reset_i = 1'b0;
        step(1'b0, idle, 1'b0);
        check("reset_v", {31'd0, v_o}, 32'd0);
        check("reset_data", data_o, 32'h0);
        check("reset_ready", {31'd0, ready_o}, 32'd1);

        // Two compressed instructions pack into one word
        step(1'b1, addi8, 1'b0);
        check("s1_no_out", {31'd0, v_o}, 32'd0);
        step(1'b1, mv, 1'b0);
        check("s1_v", {31'd0, v_o}, 32'd1);
        check("s1_data", data_o, 32'h852E0405);

        // Uncompressible from empty passes through
        step(1'b1, lui, 1'b0);
        check("s2_data", data_o, 32'h123452B7);

        // Straddle, then flush pads with C.NOP
        step(1'b1, addi8, 1'b0);
        step(1'b1, lui, 1'b0);
        check("s3_straddle", data_o, 32'h52B70405);
        step(1'b0, idle, 1'b1);
        check("s3_flush", data_o, 32'h00011234);

        // ebreak + nop
        step(1'b1, ebrk, 1'b0);
        step(1'b1, nop, 1'b0);
        check("s5_data", data_o, 32'h00019002);

        // Backpressure holds data and stalls input
        step(1'b0, idle, 1'b0);
        step(1'b1, lui, 1'b0);
        yumi_en = 1'b0;
        repeat (3) step(1'b1, and7, 1'b0);
        check("s4_hold", data_o, 32'h123452B7);
        check("s4_stall", {31'd0, ready_o}, 32'd0);
        yumi_en = 1'b1;
        step(1'b1, and7, 1'b0);
        check("s4_release", data_o, 32'h0083F3B3);

        // Flush held while the output slot is busy
        step(1'b1, addi8, 1'b0);
        step(1'b1, lui, 1'b0);
        yumi_en = 1'b0;
        repeat (2) step(1'b0, idle, 1'b1);
        check("flush_wait", data_o, 32'h52B70405);
        yumi_en = 1'b1;
        step(1'b0, idle, 1'b1);
        check("flush_late", data_o, 32'h00011234);
        step(1'b0, idle, 1'b0);

        // Reset mid-operation discards pending and unconsumed data
        step(1'b1, addi8, 1'b0);
        step(1'b1, lui, 1'b0);
        reset_i = 1'b1;
        step(1'b1, addi8, 1'b1);
        reset_i = 1'b0;
        check("s6_v", {31'd0, v_o}, 32'd0);
        check("s6_data", data_o, 32'h0);
        step(1'b1, addi8, 1'b0);
        step(1'b1, mv, 1'b0);
        check("s6_fresh", data_o, 32'h852E0405);

        // Encoding table, back to back with the consumer always ready
        for (int i = 0; i < 21; i++) begin
            step(1'b1, tbl[i], 1'b0);
            if (i == 1) check("li_pair", data_o, 32'h528152FD);
        end
        step(1'b0, idle, 1'b1);
        step(1'b0, idle, 1'b0);
        step(1'b0, idle, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
